// File: rtl/k6502_trace_buffer_if.sv
// Snooped k6502 CPU bus: address, data, direction and opcode-fetch strobe.
interface k6502_trace_buffer_if;
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw;
    logic        sync;

    modport master (output a, d, rw, sync);
    modport slave  (input  a, d, rw, sync);
endinterface

// File: rtl/k6502_trace_buffer.sv
// Bus-trace capture for the k6502: filtered, time-stamped cycles go into a show-ahead FIFO,
// and watched write addresses raise a sticky halt.
module k6502_trace_buffer #(
    parameter int DEPTH     = 16,
    parameter int NUM_WATCH = 2,
    parameter int CNT_W     = 32,
    localparam int AW  = $clog2(DEPTH),
    localparam int LW  = AW + 1,
    localparam int HIW = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1,
    localparam int DW  = CNT_W + 26
) (
    input  logic                    clk,
    input  logic                    rst,
    k6502_trace_buffer_if.slave     bus,
    input  logic [1:0]              mode,
    input  logic [16*NUM_WATCH-1:0] watch_addr,
    input  logic [NUM_WATCH-1:0]    watch_en,
    input  logic                    clr,
    input  logic                    rd_en,
    output logic                    rd_valid,
    output logic [DW-1:0]           rd_data,
    output logic [LW-1:0]           level,
    output logic                    overflow,
    output logic                    halt,
    output logic [HIW-1:0]          halt_idx
);

    logic [DW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] ts_q, ts_d;
    logic             overflow_q, overflow_d;
    logic             halt_q, halt_d;
    logic [HIW-1:0]   halt_idx_q, halt_idx_d;

    logic [1:0]       kind;
    logic             qual, push, pop, full, wr, drop;
    logic             match_any;
    logic [HIW-1:0]   match_idx;
    logic [DW-1:0]    wdata;

    always_comb begin
        kind = bus.rw ? 2'b01 : (bus.sync ? 2'b10 : 2'b00);
        unique case (mode)
            2'b01:   qual = (kind == 2'b01);
            2'b10:   qual = (kind == 2'b10);
            2'b11:   qual = 1'b1;
            default: qual = 1'b0;
        endcase
        push  = qual && !halt_q;
        pop   = rd_en && (level_q != '0);
        full  = (level_q == LW'(DEPTH));
        wr    = push && (!full || pop);
        drop  = push && full && !pop;
        wdata = {ts_q, kind, bus.a, bus.d};

        // Descending scan so the lowest matching comparator is the one reported.
        match_any = 1'b0;
        match_idx = '0;
        for (int i = NUM_WATCH - 1; i >= 0; i--) begin
            if (bus.rw && watch_en[i] && (bus.a == watch_addr[16*i +: 16])) begin
                match_any = 1'b1;
                match_idx = HIW'(i);
            end
        end

        ts_d     = ts_q + CNT_W'(1);
        wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        unique case ({wr, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        overflow_d = drop ? 1'b1 : (clr ? 1'b0 : overflow_q);

        halt_d     = halt_q;
        halt_idx_d = halt_idx_q;
        if (match_any && !halt_q) begin
            halt_d     = 1'b1;
            halt_idx_d = match_idx;
        end else if (clr) begin
            halt_d     = 1'b0;
            halt_idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
            halt_q     <= 1'b0;
            halt_idx_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            halt_q     <= halt_d;
            halt_idx_q <= halt_idx_d;
        end
    end

    // Storage array carries no reset; stale words are masked by rd_valid below.
    always_ff @(posedge clk) begin
        if (wr && !rst) mem[wr_ptr_q] <= wdata;
    end

    assign rd_valid = (level_q != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr_q] : '0;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign halt     = halt_q;
    assign halt_idx = halt_idx_q;

endmodule
